dco_dither_ctrl: RTL and testbench
==================================

Name: dco_dither_ctrl

Overview:
- Downstream of the 5-bit delta-sigma pulse generator in the ADPLL.
- Consumes its qe pulse and sign and applies a ±1 LSB dither to the integer DCO tuning code from the loop filter.
- Drives the registered code to the DCO.
- Owns code-update scheduling, dither timing, guard spacing, saturation and missed-pulse accounting.

Parameters:
- CODE_W, 8, width of the DCO tuning code.
- DITHER_LEN, 1, cycles the ±1 offset is held per accepted qe pulse (legal range 1..15).
- GUARD, 0, cycles of un-dithered output forced after each dither run (legal range 0..15).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- code_int  input  CODE_W  integer tuning code from the loop filter.
- code_valid  input  1  one-cycle strobe; code_int is valid.
- qe  input  1  dither request pulse from the DSM.
- sign  input  1  dither direction, sampled with qe: 0 = +1 LSB, 1 = -1 LSB.
- dither_en  input  1  level enable; when low, new qe pulses are ignored.
- dco_code  output  CODE_W  registered DCO control word.
- dco_update  output  1  one-cycle pulse when dco_code changed value on this edge.
- sat_hit  output  1  one-cycle pulse when a requested offset was clipped.
- ovf  output  1  sticky flag: a qe pulse was dropped.

Behaviour:
- Reset (reset_n low at rising edge):
  - Outputs: dco_code=0, dco_update=0, sat_hit=0, ovf=0.
  - Internal: base=0, base_next=0, pending=0, counters=0, state=IDLE.
  - Reset asserted mid-run aborts the dither immediately, with no finishing cycles.
- Code capture:
  - code_valid always loads base_next<=code_int.
  - base<=base_next only on edges where state is not DITHER; base is frozen during DITHER.
  - Same-cycle code_valid in IDLE or GUARD: the new code_int is used directly as the base.
- States:
  - IDLE: output = base.
  - DITHER: output = sat(base ± 1), held DITHER_LEN cycles.
  - GUARD: output = base, held GUARD cycles.
- IDLE:
  - qe & dither_en → DITHER; latch sign; cnt<=DITHER_LEN-1.
  - dco_code changes on the same edge, giving 1-cycle latency from qe to offset visible.
- DITHER:
  - cnt decrements each cycle.
  - At cnt==0, GUARD>0 → GUARD with cnt<=GUARD-1.
  - At cnt==0, GUARD==0 and pending → DITHER again using pending sign; pending cleared.
  - At cnt==0, otherwise → IDLE.
- GUARD:
  - At cnt==0, pending → DITHER (pending sign); pending cleared.
  - At cnt==0, otherwise → IDLE.
- qe & dither_en arriving in DITHER or GUARD:
  - If pending==0: pending<=1 and pending_sign<=sign.
  - If pending==1: pulse dropped, ovf<=1 (sticky until reset).
- dither_en low:
  - Ignores new qe and clears pending.
  - A dither run already in progress completes normally, including GUARD.
- Arithmetic:
  - Offset computed at CODE_W+1 bits, then clamped.
  - base=2^CODE_W-1 with sign=0 → output stays at max, sat_hit pulses on the entry edge.
  - base=0 with sign=1 → output stays 0, sat_hit pulses.
  - Never wraps.
- dco_update=1 exactly on edges where the new dco_code differs from the previous value. Clamped dithers and identical code reloads produce no pulse.
- No combinational path from any input to any output.

Test Plan:
- Reset, code_valid with code_int=0x40, then qe=1 sign=0 one cycle later (DITHER_LEN=1, GUARD=0):
  - dco_code reads 0x40.
  - Then 0x41 for one cycle, then 0x40.
  - dco_update pulses on each change.
- base=0x40, qe sign=1 with DITHER_LEN=3, GUARD=2; second qe sign=0 two cycles later:
  - Output 0x3F for 3 cycles, then 0x40 for 2 cycles, then 0x41 for 3 cycles, then 0x40.
  - ovf stays 0.
- Three qe pulses on consecutive cycles, DITHER_LEN=4 → first served, second pending, third dropped; ovf=1 and stays set until reset_n low.
- base=0xFF, qe sign=0 → dco_code stays 0xFF, sat_hit pulses once, dco_update stays 0. Same for base=0x00 with sign=1.
- code_valid 0x50 arrives mid-DITHER from base 0x40 (sign=0, DITHER_LEN=3):
  - Output stays 0x41 until run ends.
  - Then 0x50 on the exit edge.
- reset_n low during DITHER (output 0x41) → next edge: dco_code=0, state IDLE, pending=0, ovf=0.
- dither_en low with qe toggling → no offset; dither_en dropped during a run → run completes, pending cleared.

Source files
------------

// File: rtl/dco_dither_ctrl.sv
// DCO dither controller: applies a +/-1 LSB dither on top of the loop-filter
// tuning code, schedules code updates around dither runs, saturates the
// offset at the code range limits and flags dropped dither requests.
module dco_dither_ctrl #(
  parameter int CODE_W     = 8,
  parameter int DITHER_LEN = 1,
  parameter int GUARD      = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] code_int,
  input  logic              code_valid,
  input  logic              qe,
  input  logic              sign,
  input  logic              dither_en,
  output logic [CODE_W-1:0] dco_code,
  output logic              dco_update,
  output logic              sat_hit,
  output logic              ovf
);

  typedef enum logic [1:0] {ST_IDLE, ST_DITHER, ST_GUARD} state_t;

  localparam logic [3:0] LP_LEN_M1   = 4'(DITHER_LEN - 1);
  localparam logic [3:0] LP_GUARD_M1 = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_sign;
  logic                r_pend;
  logic                r_pend_sign;
  logic                r_ovf;
  logic [CODE_W-1:0]   r_base;
  logic [CODE_W-1:0]   r_base_next;
  logic [CODE_W-1:0]   r_dco_code;
  logic                r_dco_update;
  logic                r_sat_hit;

  logic                w_req;
  logic                w_pend;
  logic                w_queue;
  logic                w_run_end;
  logic                w_start;
  logic                w_start_sign;
  state_t              w_state_n;
  logic [3:0]          w_cnt_n;
  logic                w_sign_n;
  logic                w_pend_n;
  logic                w_pend_sign_n;
  logic                w_ovf_n;
  logic [CODE_W-1:0]   w_base_load;
  logic [CODE_W-1:0]   w_base_n;
  logic [CODE_W:0]     w_sum;
  logic [CODE_W-1:0]   w_clamped;
  logic [CODE_W-1:0]   w_out_n;

  // Requests only count while enabled; dropping the enable discards any queued request.
  assign w_req  = qe & dither_en;
  assign w_pend = r_pend & dither_en;

  // Sequencing: run length/guard countdown, single-entry request queue, drop accounting.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_sign_n      = r_sign;
    w_pend_n      = w_pend;
    w_pend_sign_n = r_pend_sign;
    w_ovf_n       = r_ovf;
    w_queue       = 1'b0;
    w_run_end     = 1'b0;
    w_start       = 1'b0;
    w_start_sign  = 1'b0;

    case (r_state)
      ST_DITHER: begin
        if (r_cnt != 4'd0) begin
          w_cnt_n = r_cnt - 4'd1;
          w_queue = 1'b1;
        end else if (GUARD != 0) begin
          w_state_n = ST_GUARD;
          w_cnt_n   = LP_GUARD_M1;
          w_queue   = 1'b1;
        end else begin
          w_run_end = 1'b1;
        end
      end
      ST_GUARD: begin
        if (r_cnt != 4'd0) begin
          w_cnt_n = r_cnt - 4'd1;
          w_queue = 1'b1;
        end else begin
          w_run_end = 1'b1;
        end
      end
      default: w_run_end = 1'b1;
    endcase

    // Busy: park the request if the slot is free, otherwise it is lost.
    if (w_queue && w_req) begin
      if (w_pend) begin
        w_ovf_n = 1'b1;
      end else begin
        w_pend_n      = 1'b1;
        w_pend_sign_n = sign;
      end
    end

    // Free to start: the queued request has priority; a request on the same
    // edge then takes the freed slot.
    if (w_run_end) begin
      w_state_n = ST_IDLE;
      if (w_pend) begin
        w_start       = 1'b1;
        w_start_sign  = r_pend_sign;
        w_pend_n      = w_req;
        w_pend_sign_n = sign;
      end else if (w_req) begin
        w_start      = 1'b1;
        w_start_sign = sign;
      end
    end

    if (w_start) begin
      w_state_n = ST_DITHER;
      w_cnt_n   = LP_LEN_M1;
      w_sign_n  = w_start_sign;
    end
  end

  // Base is frozen only while a dither run continues across the edge; on any
  // other edge (including the exit edge) the freshest code is used directly.
  assign w_base_load = code_valid ? code_int : r_base_next;
  assign w_base_n    = (r_state == ST_DITHER && w_state_n == ST_DITHER) ? r_base : w_base_load;

  // Offset at one extra bit: the carry/borrow bit marks a clipped result.
  assign w_sum     = w_sign_n ? ({1'b0, w_base_n} - 1'b1) : ({1'b0, w_base_n} + 1'b1);
  assign w_clamped = w_sum[CODE_W] ? (w_sign_n ? '0 : '1) : w_sum[CODE_W-1:0];
  assign w_out_n   = (w_state_n == ST_DITHER) ? w_clamped : w_base_n;

  // State, code and flag registers; all outputs come straight from here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_sign       <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_sign  <= 1'b0;
      r_ovf        <= 1'b0;
      r_base       <= '0;
      r_base_next  <= '0;
      r_dco_code   <= '0;
      r_dco_update <= 1'b0;
      r_sat_hit    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_sign       <= w_sign_n;
      r_pend       <= w_pend_n;
      r_pend_sign  <= w_pend_sign_n;
      r_ovf        <= w_ovf_n;
      r_base       <= w_base_n;
      r_base_next  <= w_base_load;
      r_dco_code   <= w_out_n;
      r_dco_update <= (w_out_n != r_dco_code);
      r_sat_hit    <= w_start & w_sum[CODE_W];
    end
  end

  assign dco_code   = r_dco_code;
  assign dco_update = r_dco_update;
  assign sat_hit    = r_sat_hit;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_dco_dither_ctrl.sv
// Bench for dco_dither_ctrl: three configurations share one stimulus stream;
// a directed vector table, hand sequences and a random run with a reference model.
module tb_dco_dither_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] code_int = '0;
  logic       code_valid = 1'b0;
  logic       qe = 1'b0;
  logic       sign = 1'b0;
  logic       dither_en = 1'b1;

  logic [2:0][7:0] codes;
  logic [2:0]      upds, sats, ovfs;

  always #5 clk = ~clk;

  dco_dither_ctrl #(.CODE_W(8), .DITHER_LEN(1), .GUARD(0)) u0 (
    .clk(clk), .reset_n(reset_n), .code_int(code_int), .code_valid(code_valid),
    .qe(qe), .sign(sign), .dither_en(dither_en),
    .dco_code(codes[0]), .dco_update(upds[0]), .sat_hit(sats[0]), .ovf(ovfs[0]));

  dco_dither_ctrl #(.CODE_W(8), .DITHER_LEN(3), .GUARD(2)) u1 (
    .clk(clk), .reset_n(reset_n), .code_int(code_int), .code_valid(code_valid),
    .qe(qe), .sign(sign), .dither_en(dither_en),
    .dco_code(codes[1]), .dco_update(upds[1]), .sat_hit(sats[1]), .ovf(ovfs[1]));

  dco_dither_ctrl #(.CODE_W(8), .DITHER_LEN(4), .GUARD(0)) u2 (
    .clk(clk), .reset_n(reset_n), .code_int(code_int), .code_valid(code_valid),
    .qe(qe), .sign(sign), .dither_en(dither_en),
    .dco_code(codes[2]), .dco_update(upds[2]), .sat_hit(sats[2]), .ovf(ovfs[2]));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: remaining dither / guard cycles plus a one-deep request slot.
  typedef struct {
    int         dit_left;
    int         grd_left;
    bit         sign;
    bit         pend;
    bit         psign;
    logic [7:0] base;
    logic [7:0] bnext;
    logic [7:0] out;
    bit         upd;
    bit         sat;
    bit         ovf;
  } mstate_t;

  mstate_t m[3];
  int      LENS[3] = '{1, 3, 4};
  int      GRDS[3] = '{0, 2, 0};

  function automatic mstate_t mstep(input mstate_t s, input int len, input int grd,
                                    input bit r, input bit cv, input logic [7:0] ci,
                                    input bit q, input bit sg, input bit en);
    mstate_t n;
    bit req, pe, free, start, ssign, was_dit, queue;
    int v;
    n = s;
    n.upd = 0;
    n.sat = 0;
    if (!r) begin
      n = '{default: 0};
      return n;
    end
    req = q && en;
    pe = s.pend && en;
    n.pend = pe;
    start = 0; ssign = 0; free = 0; queue = 0;
    was_dit = s.dit_left > 0;
    if (s.dit_left > 0) begin
      n.dit_left = s.dit_left - 1;
      if (n.dit_left == 0) begin
        if (grd > 0) begin n.grd_left = grd; queue = 1; end
        else free = 1;
      end else queue = 1;
    end else if (s.grd_left > 0) begin
      n.grd_left = s.grd_left - 1;
      if (n.grd_left == 0) free = 1; else queue = 1;
    end else free = 1;
    if (queue && req) begin
      if (pe) n.ovf = 1;
      else begin n.pend = 1; n.psign = sg; end
    end
    if (free) begin
      if (pe) begin start = 1; ssign = s.psign; n.pend = req; n.psign = sg; end
      else if (req) begin start = 1; ssign = sg; end
    end
    if (start) begin n.dit_left = len; n.sign = ssign; end
    n.bnext = cv ? ci : s.bnext;
    if (!(was_dit && n.dit_left > 0)) n.base = cv ? ci : s.bnext;
    if (n.dit_left > 0) begin
      v = int'(n.base) + (n.sign ? -1 : 1);
      if (v < 0 || v > 255) begin
        n.sat = start;
        v = (v < 0) ? 0 : 255;
      end
      n.out = 8'(v);
    end else n.out = n.base;
    n.upd = n.out != s.out;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, advance the models, compare just after the rising edge.
  task automatic step(input bit r, input bit cv, input logic [7:0] ci,
                      input bit q, input bit sg, input bit en);
    @(negedge clk);
    reset_n = r; code_valid = cv; code_int = ci; qe = q; sign = sg; dither_en = en;
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = mstep(m[i], LENS[i], GRDS[i], r, cv, ci, q, sg, en);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model u%0d dco_code", i), int'(codes[i]), int'(m[i].out));
      chk($sformatf("model u%0d dco_update", i), int'(upds[i]), int'(m[i].upd));
      chk($sformatf("model u%0d sat_hit", i), int'(sats[i]), int'(m[i].sat));
      chk($sformatf("model u%0d ovf", i), int'(ovfs[i]), int'(m[i].ovf));
    end
  endtask

  task automatic idle();
    step(1, 0, 8'h00, 0, 0, 1);
  endtask

  typedef struct {
    bit         r;
    bit         cv;
    logic [7:0] ci;
    bit         q;
    bit         sg;
    bit         en;
    logic [7:0] ec;
    bit         eu;
    bit         es;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [7:0] exp_seq[12];
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};

    // Vectors for the DITHER_LEN=1, GUARD=0 instance.
    tbl[0]  = '{0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0};
    tbl[1]  = '{1, 1, 8'h40, 0, 0, 1, 8'h40, 1, 0};
    tbl[2]  = '{1, 0, 8'h00, 1, 0, 1, 8'h41, 1, 0};
    tbl[3]  = '{1, 0, 8'h00, 0, 0, 1, 8'h40, 1, 0};
    tbl[4]  = '{1, 0, 8'h00, 0, 0, 1, 8'h40, 0, 0};
    tbl[5]  = '{1, 1, 8'hFF, 0, 0, 1, 8'hFF, 1, 0};
    tbl[6]  = '{1, 0, 8'h00, 1, 0, 1, 8'hFF, 0, 1};
    tbl[7]  = '{1, 0, 8'h00, 0, 0, 1, 8'hFF, 0, 0};
    tbl[8]  = '{1, 1, 8'h00, 0, 0, 1, 8'h00, 1, 0};
    tbl[9]  = '{1, 0, 8'h00, 1, 1, 1, 8'h00, 0, 1};
    tbl[10] = '{1, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0};
    tbl[11] = '{1, 1, 8'h40, 0, 0, 1, 8'h40, 1, 0};
    tbl[12] = '{1, 0, 8'h00, 1, 0, 0, 8'h40, 0, 0};
    tbl[13] = '{1, 0, 8'h00, 1, 1, 0, 8'h40, 0, 0};
    tbl[14] = '{1, 1, 8'h40, 0, 0, 1, 8'h40, 0, 0};
    tbl[15] = '{1, 0, 8'h00, 1, 1, 1, 8'h3F, 1, 0};
    tbl[16] = '{1, 0, 8'h00, 1, 0, 1, 8'h41, 1, 0};
    tbl[17] = '{1, 0, 8'h00, 0, 0, 1, 8'h40, 1, 0};

    for (int k = 0; k < 18; k++) begin
      step(tbl[k].r, tbl[k].cv, tbl[k].ci, tbl[k].q, tbl[k].sg, tbl[k].en);
      chk($sformatf("vec%0d dco_code", k), int'(codes[0]), int'(tbl[k].ec));
      chk($sformatf("vec%0d dco_update", k), int'(upds[0]), int'(tbl[k].eu));
      chk($sformatf("vec%0d sat_hit", k), int'(sats[0]), int'(tbl[k].es));
      chk($sformatf("vec%0d ovf", k), int'(ovfs[0]), 0);
    end

    // Two runs separated by guard (LEN=3, GUARD=2); second request queued mid-run.
    step(0, 0, 8'h00, 0, 0, 1);
    step(1, 1, 8'h40, 0, 0, 1);
    exp_seq = '{8'h3F, 8'h3F, 8'h3F, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41,
                8'h40, 8'h40, 8'h40, 8'h40};
    for (int k = 0; k < 12; k++) begin
      if (k == 0) step(1, 0, 8'h00, 1, 1, 1);
      else if (k == 2) step(1, 0, 8'h00, 1, 0, 1);
      else idle();
      chk($sformatf("guard seq %0d code", k), int'(codes[1]), int'(exp_seq[k]));
      chk($sformatf("guard seq %0d ovf", k), int'(ovfs[1]), 0);
    end

    // Three back-to-back requests (LEN=4): the third is dropped, ovf sticks.
    step(0, 0, 8'h00, 0, 0, 1);
    step(1, 1, 8'h40, 0, 0, 1);
    step(1, 0, 8'h00, 1, 0, 1);
    step(1, 0, 8'h00, 1, 1, 1);
    chk("burst ovf before drop", int'(ovfs[2]), 0);
    step(1, 0, 8'h00, 1, 0, 1);
    chk("burst ovf on drop", int'(ovfs[2]), 1);
    for (int k = 0; k < 12; k++) idle();
    chk("burst ovf sticky", int'(ovfs[2]), 1);
    chk("burst code settled", int'(codes[2]), 8'h40);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("burst ovf cleared by reset", int'(ovfs[2]), 0);

    // New code mid-run (LEN=3): held off until the exit edge.
    step(1, 1, 8'h40, 0, 0, 1);
    step(1, 0, 8'h00, 1, 0, 1);
    chk("midrun code e0", int'(codes[1]), 8'h41);
    step(1, 1, 8'h50, 0, 0, 1);
    chk("midrun code e1", int'(codes[1]), 8'h41);
    idle();
    chk("midrun code e2", int'(codes[1]), 8'h41);
    idle();
    chk("midrun code exit", int'(codes[1]), 8'h50);
    chk("midrun update exit", int'(upds[1]), 1);

    // Reset while dithering aborts at once.
    step(0, 0, 8'h00, 0, 0, 1);
    step(1, 1, 8'h40, 0, 0, 1);
    step(1, 0, 8'h00, 1, 0, 1);
    chk("abort pre code", int'(codes[1]), 8'h41);
    step(0, 0, 8'h00, 0, 0, 1);
    chk("abort code", int'(codes[1]), 8'h00);
    idle();
    chk("abort no resume", int'(codes[1]), 8'h00);

    // Enable dropped mid-run: run and guard finish, queued request is discarded.
    step(1, 1, 8'h40, 0, 0, 1);
    step(1, 0, 8'h00, 1, 0, 1);
    step(1, 0, 8'h00, 1, 1, 1);
    exp_seq = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40,
                8'h40, 8'h40, 8'h40, 8'h40};
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 8'h00, k[0], 1, 0);
      chk($sformatf("en drop %0d code", k), int'(codes[1]), int'(exp_seq[k]));
    end

    // Random traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      logic [7:0] ci;
      int sel;
      sel = $urandom_range(7);
      ci = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'h01 : 8'($urandom);
      step($urandom_range(63) != 0, $urandom_range(3) == 0, ci,
           $urandom_range(2) == 0, 1'($urandom_range(1)), $urandom_range(7) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
